// File: rtl/aes_pkg.sv
// Shared AES-128 constants and word helpers for the key expander and byte LUTs.
package aes_pkg;

  // Index 10..15 read as zero so the free-running expander past round 10 is well defined.
  localparam logic [7:0] RCON [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

endpackage

// File: rtl/aes_byte_sub_lut.sv
// Combinational single-byte AES S-box lookup; INVERSE selects the inverse table.
module aes_byte_sub_lut
  import aes_pkg::*;
#(
  parameter int INVERSE = 0
) (
  input  logic [7:0] a,
  output logic [7:0] d
);

  if (INVERSE != 0) begin : g_inv
    assign d = INV_SBOX[a];
  end else begin : g_fwd
    assign d = SBOX[a];
  end

endmodule

// File: rtl/aes_key_sched_inv_sub.sv
// AES-128 on-the-fly key expander (one round key per clock) plus a combinational
// inverse S-box port for the neighbouring InvSubBytes stage.
module aes_key_sched_inv_sub
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  input  logic [7:0]   inv_a,
  output logic [7:0]   inv_d
);

  logic [31:0] w0, w1, w2, w3;
  logic [3:0]  ridx;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_byte_sub_lut #(.INVERSE(0)) u_sbox (
      .a (rot[8*i +: 8]),
      .d (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {RCON[ridx], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Reset and load both restart RCON from index 0; ridx saturates so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      w3   <= '0;
      ridx <= '0;
    end else if (kld) begin
      w0   <= key[127:96];
      w1   <= key[95:64];
      w2   <= key[63:32];
      w3   <= key[31:0];
      ridx <= '0;
    end else begin
      w0   <= n0;
      w1   <= n1;
      w2   <= n2;
      w3   <= n3;
      if (ridx != 4'd15) ridx <= ridx + 4'd1;
    end
  end

  assign wo_0 = w0;
  assign wo_1 = w1;
  assign wo_2 = w2;
  assign wo_3 = w3;

  aes_byte_sub_lut #(.INVERSE(1)) u_inv_sbox (
    .a (inv_a),
    .d (inv_d)
  );

endmodule

// File: tb/tb_aes_key_sched_inv_sub.sv
// Directed bench for the AES-128 key expander and inverse S-box port.
module tb_aes_key_sched_inv_sub;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic [7:0]   inv_a;
  logic [7:0]   inv_d;

  int compared = 0;
  int mismatched = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  aes_key_sched_inv_sub dut (
    .clk   (clk),
    .rst   (rst),
    .kld   (kld),
    .key   (key),
    .wo_0  (wo_0),
    .wo_1  (wo_1),
    .wo_2  (wo_2),
    .wo_3  (wo_3),
    .inv_a (inv_a),
    .inv_d (inv_d)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rk(input string tag, input logic [127:0] expected);
    logic [127:0] observed;
    observed = {wo_0, wo_1, wo_2, wo_3};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Independent forward S-box: GF(2^8) inverse followed by the affine transform.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = x; bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  initial begin
    rst = 1'b1; kld = 1'b0; key = '0; inv_a = 8'h00;
    step();
    chk_rk("reset_state", 128'h0);

    rst = 1'b0; kld = 1'b1; key = FIPS_KEY;
    step();
    chk_rk("fips_rk0", FIPS_KEY);
    kld = 1'b0;
    step();
    chk_rk("fips_rk1", FIPS_RK1);
    step();
    chk_rk("fips_rk2", FIPS_RK2);
    for (int r = 3; r <= 10; r++) step();
    chk_rk("fips_rk10", FIPS_RK10);

    step();
    rst = 1'b1; kld = 1'b1;
    step();
    chk_rk("rst_over_kld", 128'h0);
    rst = 1'b0; kld = 1'b1; key = FIPS_KEY;
    step();
    chk_rk("reload_rk0", FIPS_KEY);
    kld = 1'b0;
    step();
    chk_rk("reload_rk1", FIPS_RK1);

    kld = 1'b1; key = '0;
    step();
    chk_rk("zero_rk0", 128'h0);
    kld = 1'b0;
    step();
    chk_rk("zero_rk1", ZERO_RK1);
    step();
    chk_rk("zero_rk2", ZERO_RK2);
    for (int r = 3; r <= 5; r++) step();
    kld = 1'b1; key = '0;
    step();
    chk_rk("midexp_reload_rk0", 128'h0);
    kld = 1'b0;
    step();
    chk_rk("midexp_reload_rk1", ZERO_RK1);

    kld = 1'b1; key = FIPS_KEY;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_rk("kld_held_rk0", FIPS_KEY);
    end
    kld = 1'b0;
    step();
    chk_rk("kld_held_release_rk1", FIPS_RK1);

    inv_a = 8'h00; #1 chk_byte("inv_00", inv_d, 8'h52);
    inv_a = 8'h01; #1 chk_byte("inv_01", inv_d, 8'h09);
    inv_a = 8'h63; #1 chk_byte("inv_63", inv_d, 8'h00);
    inv_a = 8'h7c; #1 chk_byte("inv_7c", inv_d, 8'h01);
    inv_a = 8'hff; #1 chk_byte("inv_ff", inv_d, 8'h7d);
    inv_a = 8'h52; #1 chk_byte("inv_52", inv_d, 8'h48);

    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb;
      xb = 8'(x);
      rst = xb[4];
      inv_a = sbox_model(xb);
      #1;
      chk_byte("inv_roundtrip", inv_d, xb);
      if (x % 32 == 31) step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_inv_sub.md
Name: aes_key_sched_inv_sub

Overview:
- AES-128 decryption support block combining two functions:
  - a sequential on-the-fly key expander that emits one 128-bit round key per clock after a key load;
  - a combinational AES inverse S-box byte lookup.
- Sits beside the inverse-cipher datapath. The datapath buffers round keys 0..10 from this block and uses the inverse S-box for InvSubBytes.

Parameters:
- none (AES-128 only; 10 rounds fixed).

Ports:
- clk      input   1    rising-edge clock, single domain.
- rst      input   1    reset; synchronous to clk, active-high.
- kld      input   1    key load strobe, sampled at rising edge.
- key      input   128  cipher key; key[127:96] is word 0 and key[31:0] is word 3.
- wo_0     output  32   current round-key word 0 (most significant word of the round key).
- wo_1     output  32   current round-key word 1.
- wo_2     output  32   current round-key word 2.
- wo_3     output  32   current round-key word 3.
- inv_a    input   8    inverse S-box lookup input byte.
- inv_d    output  8    inverse S-box of inv_a; purely combinational.

Behaviour:
- Registers are w0..w3 (32 bits each) and a round-constant index ridx (4 bits). wo_i = w_i directly, with no extra output register.
- Priority at each rising edge, highest first:
  - rst=1: w0..w3 <= 0, ridx <= 0.
  - else kld=1: w0 <= key[127:96], w1 <= key[95:64], w2 <= key[63:32], w3 <= key[31:0], ridx <= 0.
  - else (expand step):
    - t = SubWord(RotWord(w3)) ^ {RCON[ridx], 24'h0}.
    - RotWord(x) = {x[23:0], x[31:24]}.
    - SubWord applies the forward S-box to each byte.
    - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
    - w0..w3 <= n0..n3; ridx <= ridx+1, saturating at 15.
- RCON[0..9] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. RCON[10..15] = 00.
- Latency: if kld is sampled at edge E, round key 0 (the raw key) is on wo after E, and round key k (1..10) is on wo after edge E+k.
- Expansion free-runs with no done flag. Beyond round 10 the outputs keep changing using RCON=00; consumers must capture rounds 0..10.
- kld held high for several cycles: the key reloads every cycle and round key 0 persists.
- kld asserted mid-expansion: restart immediately; the new key appears after that edge.
- rst asserted mid-expansion: outputs go to zero after the edge; rst overrides kld.
- inv_d = InvSBox(inv_a) per FIPS-197 Figure 14. It is combinational with no clock/reset dependence and is valid in the same cycle as inv_a.
- No X propagation from reset: all state is defined after a single reset edge.

Decomposition:
- Package aes_pkg holds:
  - the RCON constant array (16 entries, with zeros for indices 10..15);
  - the 256-entry forward S-box and inverse S-box constant tables as 8-bit arrays;
  - functions rot_word and sub_word.
- One sub-module, aes_byte_sub_lut:
  - parameter INVERSE (0 or 1); 8-bit a in, 8-bit d out, combinational table lookup from aes_pkg.
  - Instantiated 4× with INVERSE=0 for SubWord and 1× with INVERSE=1 for inv_a/inv_d.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, kld for one cycle:
  - after the load edge, wo = 2b7e1516 28aed2a6 abf71588 09cf4f3c;
  - +1 edge: a0fafe17 88542cb1 23a33939 2a6c7605;
  - +10 edges: d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- All-zero key: round 1 = 62636363 62636363 62636363 62636363; round 2 = 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
- rst=1 during expansion (with kld=1 in the same cycle): wo_0..3 = 0 after the edge. Then kld of the FIPS key: round 1 = a0fafe17... exactly one edge after load.
- kld reasserted at round 5 with the all-zero key: wo = 0 after that edge; next edge wo = 62636363 ×4 (RCON restarts at 01).
- Inverse S-box sweep:
  - 00→52, 01→09, 63→00, 7c→01, ff→7d, 52→48.
  - Exhaustive check that InvSBox(SBox(x)) = x for all 256 x, independent of clk and rst.
